// File: rtl/ifetch_buffer_pkg.sv
// Shared fetch-stage constants and the prefetch entry layout.
package ifetch_buffer_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ILEN         = 32;
  localparam int unsigned IFETCH_DEPTH = 2;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] IFETCH_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            filled;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_ring.sv
// Prefetch ring: entry storage, alloc/fill/head pointers and occupancy counters.
module ifetch_ring
  import ifetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IFETCH_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc,
  input  logic [XLEN-1:0]         alloc_pc,
  input  logic                    fill,
  input  logic [ILEN-1:0]         fill_inst,
  input  logic                    pop,
  input  logic                    flush,
  output logic                    head_valid,
  output logic [XLEN-1:0]         head_pc,
  output logic [ILEN-1:0]         head_inst,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  ifetch_entry_t   ent [DEPTH];
  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   head_ptr;
  logic            pop_ok;

  assign head_valid = (count != '0) && ent[head_ptr].filled;
  assign head_pc    = ent[head_ptr].pc;
  assign head_inst  = ent[head_ptr].inst;
  assign pop_ok     = pop && head_valid;

  // pending tracks allocated-but-unfilled entries so a flush knows how many responses it orphans
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ent[i] <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pending   <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) ent[i].filled <= 1'b0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pending   <= '0;
    end else begin
      if (alloc) begin
        ent[alloc_ptr].pc     <= alloc_pc;
        ent[alloc_ptr].filled <= 1'b0;
        alloc_ptr             <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        ent[fill_ptr].inst   <= fill_inst;
        ent[fill_ptr].filled <= 1'b1;
        fill_ptr             <= fill_ptr + PW'(1);
      end
      if (pop_ok) head_ptr <= head_ptr + PW'(1);
      count   <= count + CW'(alloc) - CW'(pop_ok);
      pending <= pending + CW'(alloc) - CW'(fill);
    end
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: memory request handshake, stale-response dropping, decode interface.
// Optional build macro IFETCH_PERF_EN adds perf_stall_cycles / perf_flushed counters.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int unsigned     DEPTH    = IFETCH_DEPTH,
  parameter logic [ILEN-1:0] NOP_INST = IFETCH_NOP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_addr,
  output logic             pc_advance,
  input  logic             redirect,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [ILEN-1:0]  id_inst,
  input  logic             id_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_flushed
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   count;
  logic [CW-1:0]   pending;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_nxt;
  logic [CW:0]     occupancy;
  logic            handshake;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_inst;

  // Request gating and response steering
  always_comb begin
    occupancy      = (CW+1)'(count) + (CW+1)'(drop_cnt);
    imem_req_valid = !rst && !redirect && (occupancy < (CW+1)'(DEPTH));
    imem_req_addr  = pc_addr;
    handshake      = imem_req_valid && imem_req_ready;
    pc_advance     = handshake;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    rsp_fill       = imem_rsp_valid && (drop_cnt == '0) && !redirect;
    drop_nxt       = drop_cnt;
    if (redirect)
      drop_nxt = drop_cnt + pending - CW'(imem_rsp_valid);
    else if (rsp_drop)
      drop_nxt = drop_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= drop_nxt;
  end

  ifetch_ring #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk),
    .rst        (rst),
    .alloc      (handshake),
    .alloc_pc   (pc_addr),
    .fill       (rsp_fill),
    .fill_inst  (imem_rsp_data),
    .pop        (id_ready),
    .flush      (redirect),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst),
    .count      (count),
    .pending    (pending)
  );

  assign id_valid = head_valid;
  assign id_pc    = head_pc;
  assign id_inst  = head_valid ? head_inst : NOP_INST;

  // A response must always have an owner: either a stale slot or an unfilled entry
  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((drop_cnt != '0) || (pending != '0)));

`ifdef IFETCH_PERF_EN
  logic          rsp_stale;
  logic [CW:0]   flush_inc;
  logic [32:0]   flush_sum;

  // Filled entries are counted at the flush; unfilled ones when their stale response is dropped
  always_comb begin
    rsp_stale = imem_rsp_valid && ((drop_cnt != '0) || redirect);
    flush_inc = (CW+1)'(rsp_stale);
    if (redirect) flush_inc = flush_inc + (CW+1)'(count - pending);
    flush_sum = {1'b0, perf_flushed} + 33'(flush_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flushed      <= '0;
    end else begin
      if (!id_valid && !redirect && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      perf_flushed <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: random memory/decode timing against a queue-level model.
module tb_ifetch_buffer;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_advance;
  logic        redirect;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushed;
`endif

  ifetch_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_addr        (pc_addr),
    .pc_advance     (pc_advance),
    .redirect       (redirect),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_ready       (id_ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushed      (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: fetched-but-not-consumed instructions, and the memory's in-flight list
  typedef struct { logic [31:0] pc; bit filled; } qent_t;
  typedef struct { logic [31:0] pc; int due; bit stale; } mreq_t;
  qent_t q[$];
  mreq_t mq[$];

  int          cyc = 0;
  int          last_due = 0;
  logic [31:0] pc = 32'h0;
  int          n_vec = 0;
  int          n_err = 0;
  int          ready_pct = 100;
  int          idr_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
`ifdef IFETCH_PERF_EN
  int          stall_model = 0;
`endif

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mq[i]) if (mq[i].stale) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive after posedge, check on negedge, advance the model at the posedge
  task automatic cycle(input bit redir, input logic [31:0] tgt);
    bit    rsp_now, exp_rv, exp_idv, hs, popd;
    int    lat, d;
    mreq_t m;
    rsp_now        = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_req_ready = ($urandom_range(99) < ready_pct);
    id_ready       = ($urandom_range(99) < idr_pct);
    redirect       = redir;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_fn(mq[0].pc) : $urandom();
    pc_addr        = pc;
    @(negedge clk);
    exp_rv  = !redir && (q.size() + stale_cnt() < DEPTH);
    exp_idv = (q.size() > 0) && q[0].filled;
    hs      = exp_rv && imem_req_ready;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("pc_advance", 32'(pc_advance), 32'(hs));
    if (exp_rv) chk("req_addr", imem_req_addr, pc);
    chk("id_valid", 32'(id_valid), 32'(exp_idv));
    if (exp_idv) begin
      chk("id_pc", id_pc, q[0].pc);
      chk("id_inst", id_inst, mem_fn(q[0].pc));
    end else begin
      chk("id_inst_nop", id_inst, NOP);
    end
`ifdef IFETCH_PERF_EN
    chk("perf_stall", perf_stall_cycles, 32'(stall_model));
`endif
    popd = exp_idv && id_ready && !redir;
    @(posedge clk);
`ifdef IFETCH_PERF_EN
    if (!exp_idv && !redir) stall_model++;
`endif
    if (rsp_now) begin
      m = mq.pop_front();
      if (!m.stale && !redir) begin
        foreach (q[i]) if (!q[i].filled) begin q[i].filled = 1'b1; break; end
      end
    end
    if (redir) begin
      q.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      pc = tgt;
    end else begin
      if (popd) void'(q.pop_front());
      if (hs) begin
        q.push_back('{pc: pc, filled: 1'b0});
        lat = int'($urandom_range(lat_max, lat_min));
        d   = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        mq.push_back('{pc: pc, due: d, stale: 1'b0});
        last_due = d;
        pc = pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic async_reset();
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_advance", 32'(pc_advance), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_inst", id_inst, NOP);
`ifdef IFETCH_PERF_EN
    chk("rst_perf_stall", perf_stall_cycles, 32'd0);
    chk("rst_perf_flushed", perf_flushed, 32'd0);
    stall_model = 0;
`endif
    q.delete();
    mq.delete();
    pc = 32'h0;
    last_due = cyc;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: condition not reached within cycle budget", tag);
  endtask

  initial begin
    logic [31:0] tgt;
    bit          found;
    rst = 1'b0; redirect = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; id_ready = 1'b0; pc_addr = '0;
    #1;
    async_reset();

    // Streaming at single-cycle latency
    repeat (12) cycle(1'b0, 32'h0);

    // Decode stalled: the queue fills and the PC holds
    idr_pct = 0;
    repeat (8) cycle(1'b0, 32'h0);
    idr_pct = 100;
    repeat (4) cycle(1'b0, 32'h0);

    // Redirect with two requests in flight at latency 3
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 2 && stale_cnt() == 0) begin found = 1'b1; break; end
      cycle(1'b0, 32'h0);
    end
    if (!found) timeout("two_in_flight");
    cycle(1'b1, 32'h0000_0100);
    repeat (12) cycle(1'b0, 32'h0);

    // Redirect coinciding with the only outstanding response
    lat_min = 1; lat_max = 1; ready_pct = 50;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mq.size() == 1 && mq[0].due <= cyc && !mq[0].stale) begin found = 1'b1; break; end
      cycle(1'b0, 32'h0);
    end
    if (!found) timeout("rsp_with_redirect");
    cycle(1'b1, 32'h0000_0200);
    repeat (8) cycle(1'b0, 32'h0);

    // Random traffic with occasional redirects
    ready_pct = 70; idr_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      tgt = $urandom();
      tgt[1:0] = 2'b00;
      cycle($urandom_range(24) == 0, tgt);
    end

    // Asynchronous reset with two filled entries waiting
    ready_pct = 100; idr_pct = 0; lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (q.size() == 2 && q[0].filled && q[1].filled) begin found = 1'b1; break; end
      cycle(1'b0, 32'h0);
    end
    if (!found) timeout("two_filled");
    async_reset();

    ready_pct = 80; idr_pct = 80; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 500; i++) begin
      tgt = $urandom();
      tgt[1:0] = 2'b00;
      cycle($urandom_range(30) == 0, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the PC's current instruction address and issues read requests to instruction memory with a valid/ready handshake.
- Collects in-order responses into a small prefetch queue and presents {pc, instruction} to decode.
- Produces the go_next advance pulse that steps the PC, and flushes all queued and in-flight fetches on a taken jump.

Parameters:
- DEPTH, 2, queue entries; power of two, >= 2; also bounds outstanding memory requests.
- NOP_INST, 32'h0000_0013, value driven on id_inst when id_valid = 0.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- pc_addr  in  32  current fetch address from the PC; must be stable until pc_advance.
- pc_advance  out  1  go_next to the PC; pulses for each accepted request.
- redirect  in  1  one-cycle pulse: jump taken, flush everything; the PC presents the target on pc_addr from the next cycle.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  32  request address (= pc_addr).
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  response valid; responses return in request order, latency >= 1.
- imem_rsp_data  in  32  instruction word.
- id_valid  out  1  head entry holds a filled instruction.
- id_pc  out  32  address of the head instruction.
- id_inst  out  32  head instruction; NOP_INST when id_valid = 0.
- id_ready  in  1  decode consumes the head.

Behaviour:
- Storage: ring of DEPTH entries {pc[31:0], inst[31:0], filled}.
  - Pointers: alloc_ptr, fill_ptr, head_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count: entries allocated (0..DEPTH).
  - drop_cnt: stale responses still owed (0..DEPTH).
- Request:
  - imem_req_valid = !rst_state && !redirect && (count + drop_cnt < DEPTH).
  - Handshake fires on imem_req_valid & imem_req_ready.
  - On handshake: allocate the entry at alloc_ptr with pc = pc_addr and filled = 0, then alloc_ptr++.
  - pc_advance = the handshake, combinational, same cycle.
- Response:
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Else: write imem_rsp_data into the entry at fill_ptr, set filled = 1, fill_ptr++.
  - A response arriving with no allocated unfilled entry and drop_cnt = 0 is illegal (protocol assertion).
- Output:
  - id_valid = (count > 0) && entry[head_ptr].filled.
  - id_pc and id_inst come from the head entry.
  - Outputs are registered-state driven; no combinational path from imem_rsp to id_*.
  - Minimum fetch-to-decode latency: memory latency + 1 cycle.
- Pop: id_valid & id_ready frees the head (head_ptr++, count--).
- Simultaneous events:
  - Request and pop in the same cycle: count unchanged.
  - Request, response and pop in the same cycle: all three act independently.
- Redirect (flush):
  - count <- 0; all pointers <- 0; all filled bits cleared.
  - drop_cnt <- (drop_cnt + number of allocated unfilled entries) − (1 if imem_rsp_valid in this cycle, else 0). A same-cycle response is treated as stale and discarded.
  - Request is suppressed in the redirect cycle.
  - Any pop in the redirect cycle is ignored; flush wins.
- Full queue (count + drop_cnt = DEPTH): imem_req_valid = 0 and pc_advance = 0; the PC holds.
- Reset (asynchronous, any time including mid-transaction):
  - All pointers, count, drop_cnt and filled bits <- 0.
  - imem_req_valid = 0, pc_advance = 0, id_valid = 0, id_pc = 0, id_inst = NOP_INST.
  - The memory must also be reset; in-flight responses are not tracked across reset.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- With the macro: adds output ports perf_stall_cycles[31:0] and perf_flushed[31:0].
  - perf_stall_cycles increments each cycle that id_valid = 0 and no redirect is asserted.
  - perf_flushed increments by the number of entries discarded per redirect, allocated or stale; the stale count is added when the drop occurs.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Without the macro: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/define file (alongside the existing PC-jump defines): NOP instruction constant 32'h0000_0013, default IFETCH_DEPTH, and the entry field widths.
- One natural sub-module: ifetch_ring, holding the entry storage, the three pointers and count. It exposes alloc/fill/pop/flush strobes and head data.
- The top level holds the handshake logic, drop_cnt and the perf counters.

Test Plan:
- Reset, then memory with 1-cycle latency, always ready, id_ready = 1, pc_addr stepping 0, 4, 8 on pc_advance -> id_pc sequence 0, 4, 8 with matching insts; first id_valid 2 cycles after the first request.
- id_ready = 0, DEPTH = 2 -> exactly 2 requests (pc 0, 4), then imem_req_valid = 0 and pc_advance = 0 until one pop; next request pc = 8.
- Memory latency 3 with 2 requests in flight; redirect pulse, target 0x100 -> both stale responses dropped (drop_cnt 2→1→0); first id_pc after flush = 0x100.
- Redirect in the same cycle as imem_rsp_valid with 1 outstanding -> drop_cnt = 0; that response never appears on id_inst; no request in the redirect cycle.
- Simultaneous request, response and pop with count = 1 -> count remains 1; pointer order preserved; id sequence unbroken.
- rst asserted mid-stream with 2 entries filled -> id_valid = 0 and id_inst = 0x00000013 immediately (asynchronous); with IFETCH_PERF_EN, both counters read 0.
